// File: rtl/data_mem_responder.sv
// Handshaked, fixed-latency data-memory responder backed by a byte-enabled 32-bit word RAM.
// Optional build macro: MISALIGN_CHECK_EN (error response on non-word-aligned addresses).
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic           write_q;
    logic           mis_q;
    logic [31:0]    rdata_q;
    logic           err_q;
    logic           misaligned;
    logic           accept;
    logic           do_access;

    logic [31:0]    mem [DEPTH_WORDS];

`ifdef MISALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Bits outside the word index never influence the access (aliasing).
    logic unused_addr;
    assign unused_addr = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            // The counter is loaded with WAIT_CYCLES and the access fires once it
            // has drained to zero, giving 1+WAIT_CYCLES edges from acceptance to response.
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            write_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= 4'(WAIT_CYCLES);
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
                write_q <= req_write;
                mis_q   <= misaligned;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (do_access) begin
                err_q   <= mis_q;
                rdata_q <= (write_q || mis_q) ? 32'd0 : mem[idx_q];
            end
        end
    end

    // NOTE: the RAM array has no reset; a reset on the access edge only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && write_q && !mis_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITS = 2;
    localparam int LAT   = 1 + WAITS;
    localparam int BOUND = 40;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request (called #1 after an edge), waits for the response, then completes it.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rdata,
                           output logic err, output int lat);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rdata      = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0404, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'h0102_0304, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
        end

        // Backpressure: hold the load response for 5 cycles and poke a request at it.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < BOUND) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(LAT));
        for (int c = 0; c < 5; c++) begin
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
            check("bp_resp_err",   {31'd0, resp_err},  32'd0);
            check("bp_req_ready",  {31'd0, req_ready}, 32'd0);
            if (c == 2) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
                req_wdata = 32'h0; req_be = 4'hF;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_idle_busy",      {31'd0, busy},       32'd0);
        check("bp_idle_req_ready", {31'd0, req_ready},  32'd1);
        check("bp_idle_resp_valid",{31'd0, resp_valid}, 32'd0);
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("bp_ignored_store", rd, 32'hDEAD_BEEF);

        // Reset on the very edge that would perform the store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h1234_5678; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        check("rstw_busy_wait", {31'd0, busy}, 32'd1);
        for (int c = 0; c < WAITS; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy",       {31'd0, busy},       32'd0);
        check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
        for (int c = 0; c < 5; c++) tick();
        check("rstw_no_resp",    {31'd0, resp_valid}, 32'd0);
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        check("rstw_mem_kept", rd, 32'h0);

`ifdef MISALIGN_CHECK_EN
        run_txn(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
        check("mis_load_err",   {31'd0, er}, 32'd1);
        check("mis_load_rdata", rd, 32'h0);
        check("mis_load_lat",   32'(lat), 32'(LAT));
        run_txn(1'b1, 32'h21, 32'h9999_9999, 4'hF, rd, er, lat);
        check("mis_store_err",  {31'd0, er}, 32'd1);
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        check("mis_store_kept", rd, 32'h0);
        check("mis_clean_err",  {31'd0, er}, 32'd0);
`else
        run_txn(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
        check("unaligned_err",  {31'd0, er}, 32'd0);
        run_txn(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        check("unaligned_rdata", rd, 32'hDEAD_BEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
